ifu_pc_gen: RTL
===============

# ifu_pc_gen

Fetch-stage program-counter generator and instruction-memory requester, sitting directly upstream of the branch target buffer. It owns the architectural fetch PC, drives the BTB query each cycle, and issues one instruction-memory request at a time. It applies the BTB prediction to choose the next PC and absorbs redirects from execute. Fetched instructions, tagged with PC and prediction, go to the IF/ID register over a valid/ready handshake.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- btb_pc_query  out  32  current fetch PC, wired to the BTB query port
- btb_lookup_en  out  1  BTB lookup enable (drives BTB is_jump); high in REQ
- btb_hit  in  1  BTB hit for btb_pc_query (combinational)
- btb_target  in  32  BTB predicted target for btb_pc_query
- imem_req_valid  out  1  instruction request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  request address (= fetch PC)
- imem_resp_valid  in  1  response valid, single-cycle pulse
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  execute-stage redirect (mispredict/exception)
- redirect_pc  in  32  redirect target
- out_valid  out  1  instruction available to IF/ID
- out_ready  in  1  IF/ID accepts
- out_pc, out_inst, out_pred_target  out  32 each  PC, instruction, predicted next PC
- out_pred_taken  out  1  BTB hit recorded at request acceptance

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Reset: state IDLE, pc=RESET_PC, kill=0, all valid outputs 0, out_* data 0.
- IDLE: one cycle, then REQ unconditionally. A redirect in IDLE loads pc=redirect_pc.
- REQ: imem_req_valid=1, addr=pc. On accept (valid&ready), register pred_taken=btb_hit and pred_target=btb_hit?btb_target:pc+4, then go to WAIT.
- WAIT: await imem_resp_valid. On a response with kill=0, capture out_pc=pc and out_inst, load pc=pred_target, and go to HOLD. With kill=1, discard it, clear kill, and go to REQ.
- HOLD: out_valid=1. On out_ready go to REQ; otherwise hold all out_* stable.
- Redirect, which has highest priority in every state:
  - REQ: pc=redirect_pc and stay in REQ. Not accepted: the address change is permitted. Accepted the same cycle: the in-flight request is killed (kill=1, go to WAIT).
  - WAIT: pc=redirect_pc, kill=1. A response arriving the same cycle is discarded; clear kill and go to REQ.
  - HOLD: drop out_valid next cycle, pc=redirect_pc, go to REQ. An out_valid&out_ready transfer in the redirect cycle is void; IF/ID flushes on the same redirect.
- pc+4 wraps modulo 2^32, so 32'hFFFF_FFFC+4=0. Low two PC bits pass through unmodified; no alignment check.
- Reset asserted mid-transaction returns to IDLE; a late memory response is ignored because the FSM is not in WAIT.

## Timing
- Only one request is outstanding. The response arrives no earlier than the cycle after acceptance; a response outside WAIT is ignored.
- Best case is one instruction per 3 cycles: REQ (accepted), WAIT (resp), HOLD (out_ready).
- The BTB is read combinationally in the acceptance cycle; prediction has no extra latency.
- The redirect PC appears on imem_req_addr the cycle after redirect_valid (or one cycle after the kill is resolved in WAIT).
- out_* change only on entry to HOLD; stable while out_valid&!out_ready.

## Structure
- Shared fetch package holds the FSM state enum, the 32'h4 instruction stride constant and the RESET_PC default, shared with the BTB and IF/ID register.
- Single module, no sub-modules; the next-PC mux is inline.

## Test plan
- Reset then ready=1, resp one cycle later, no BTB hit -> first req addr 8000_0000, second 8000_0004, out_pred_taken=0.
- BTB hit at 8000_0008, target 8000_0100 -> out_pred_taken=1, out_pred_target=8000_0100, next req addr 8000_0100.
- Redirect to 8000_0200 in WAIT, resp next cycle with 0xDEADBEEF -> no out_valid, next req addr 8000_0200.
- out_ready held 0 for 5 cycles in HOLD -> out_pc/out_inst stable, no new request; release -> REQ next cycle.
- PC=FFFF_FFFC, no hit -> next req addr 0000_0000.
- rst asserted in WAIT, resp arrives the following cycle -> no out_valid, the first request after reset is to 8000_0000.

Source files
------------

// File: rtl/ifu_pc_gen_pkg.sv
// Shared fetch-stage definitions: FSM encoding, instruction stride and reset PC,
// also used by the BTB and the IF/ID register.
package ifu_pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INST_STRIDE      = 32'h0000_0004;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu_pc_gen.sv
// Fetch PC generator: owns the fetch PC, queries the BTB, issues one imem request
// at a time and hands PC/instruction/prediction to IF/ID over valid/ready.
module ifu_pc_gen
    import ifu_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    output logic [31:0] btb_pc_query,
    output logic        btb_lookup_en,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_pred_target,
    output logic        out_pred_taken
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [31:0] pc;
    logic        kill;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        req_fire;

    assign req_fire      = (state == ST_REQ) && imem_req_ready;
    assign btb_pc_query  = pc;
    assign imem_req_addr = pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ: begin
                if (req_fire) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    state_nxt = (kill || redirect_valid) ? ST_REQ : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || out_ready) begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        btb_lookup_en  = 1'b0;
        out_valid      = 1'b0;
        case (state)
            ST_REQ: begin
                imem_req_valid = 1'b1;
                btb_lookup_en  = 1'b1;
            end
            ST_HOLD: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Fetch PC, kill flag, captured prediction and the IF/ID-facing payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_PC;
            kill            <= 1'b0;
            pred_taken      <= 1'b0;
            pred_target     <= '0;
            out_pc          <= '0;
            out_inst        <= '0;
            out_pred_taken  <= 1'b0;
            out_pred_target <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                end
                ST_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (req_fire) begin
                        // An accepted request in a redirect cycle fetches a stale PC.
                        kill        <= redirect_valid;
                        pred_taken  <= btb_hit;
                        pred_target <= btb_hit ? btb_target : pc + INST_STRIDE;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        pc   <= redirect_pc;
                        kill <= !imem_resp_valid;
                    end else if (imem_resp_valid) begin
                        if (kill) begin
                            kill <= 1'b0;
                        end else begin
                            out_pc          <= pc;
                            out_inst        <= imem_resp_data;
                            out_pred_taken  <= pred_taken;
                            out_pred_target <= pred_target;
                            pc              <= pred_target;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
